lq_agen_seq: RTL and testbench

Byte-serial effective-address sequencer for the LQ AGEN slice. Two thread requesters share one 8-bit carry-select adder slice (lq_agen_loca: inverted operands in, sum_0 for carry-in 0 and sum_1 for carry-in 1 out). The block arbitrates between the threads, captures the operands, and steps the slice across the address one byte per cycle, least-significant byte first. Each step selects sum_0 or sum_1 from the running carry. The block returns a 64-bit EA and the final carry-out to the LQ pipe.

---
 rtl/lq_agen_seq.sv | 181 ++++++++++++++++++
 tb/tb_lq_agen_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lq_agen_seq.sv
// Byte-serial EA sequencer: arbitrates two threads and steps one 8-bit carry-select slice LSB byte first.
// Result 9 (64-bit) / 5 (32-bit) cycles after capture; result held in DONE while res_hold, flush aborts.

module lq_agen_loca (
  input  logic [7:0] a_b,
  input  logic [7:0] b_b,
  output logic [7:0] sum_0,
  output logic [7:0] sum_1,
  output logic       g,
  output logic       p
);
  logic [8:0] s;

  assign s     = {1'b0, ~a_b} + {1'b0, ~b_b};
  assign sum_0 = s[7:0];
  assign sum_1 = s[7:0] + 8'd1;
  assign g     = s[8];
  assign p     = (s == 9'h0FF);
endmodule

module lq_agen_seq #(
  parameter int EA_WIDTH = 64
) (
  input  logic                nclk,
  input  logic                rst_b,
  input  logic                t0_req_val,
  input  logic                t1_req_val,
  input  logic [0:EA_WIDTH-1] t0_ra,
  input  logic [0:EA_WIDTH-1] t1_ra,
  input  logic [0:EA_WIDTH-1] t0_rb,
  input  logic [0:EA_WIDTH-1] t1_rb,
  input  logic                t0_cm,
  input  logic                t1_cm,
  output logic                t0_req_ack,
  output logic                t1_req_ack,
  input  logic [1:0]          flush,
  input  logic                res_hold,
  output logic                res_val,
  output logic                res_tid,
  output logic [0:EA_WIDTH-1] res_ea,
  output logic                res_cry,
  output logic                busy
);
  localparam int NB = EA_WIDTH / 8;
  localparam int CW = $clog2(NB);
  localparam int BW = $clog2(EA_WIDTH);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic [0:EA_WIDTH-1] ra_q, ra_d, rb_q, rb_d;
  logic                cm_q, cm_d, tid_q, tid_d, last_q, last_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic                val_q, val_d, cry_q, cry_d;
  logic [0:EA_WIDTH-1] ea_q, ea_d;

  logic          elig0, elig1, gnt_vld, gnt_tid;
  logic [CW-1:0] byte_j, last_cnt;
  logic [BW-1:0] bidx;
  logic [7:0]    ra_byte, rb_byte, sum_0, sum_1;
  logic          g, p, carry_nxt;

  assign elig0   = t0_req_val & ~flush[0];
  assign elig1   = t1_req_val & ~flush[1];
  assign gnt_vld = elig0 | elig1;
  // Tie goes to the thread not granted last.
  assign gnt_tid = (elig0 & elig1) ? ~last_q : elig1;

  assign byte_j    = CW'(NB - 1) - cnt_q;
  assign bidx      = {byte_j, 3'b000};
  assign last_cnt  = cm_q ? CW'(NB - 1) : CW'(NB / 2 - 1);
  assign ra_byte   = ra_q[bidx +: 8];
  assign rb_byte   = rb_q[bidx +: 8];
  assign carry_nxt = g | (p & carry_q);

  lq_agen_loca u_loca (
    .a_b   (~ra_byte),
    .b_b   (~rb_byte),
    .sum_0 (sum_0),
    .sum_1 (sum_1),
    .g     (g),
    .p     (p)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    cm_d    = cm_q;
    tid_d   = tid_q;
    last_d  = last_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    val_d   = val_q;
    cry_d   = cry_q;
    ea_d    = ea_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d = ADD;
          tid_d   = gnt_tid;
          last_d  = gnt_tid;
          ra_d    = gnt_tid ? t1_ra : t0_ra;
          rb_d    = gnt_tid ? t1_rb : t0_rb;
          cm_d    = gnt_tid ? t1_cm : t0_cm;
          cnt_d   = '0;
          carry_d = 1'b0;
          cry_d   = 1'b0;
          ea_d    = '0;
          ack0_d  = ~gnt_tid;
          ack1_d  = gnt_tid;
        end
      end
      ADD: begin
        if (flush[tid_q]) begin
          state_d = IDLE;
        end else begin
          ea_d[bidx +: 8] = carry_q ? sum_1 : sum_0;
          carry_d         = carry_nxt;
          cnt_d           = cnt_q + CW'(1);
          if (cnt_q == last_cnt) begin
            cry_d   = carry_nxt;
            val_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (flush[tid_q] || !res_hold) begin
          val_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge nclk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ra_q    <= '0;
      rb_q    <= '0;
      cm_q    <= 1'b0;
      tid_q   <= 1'b0;
      last_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      val_q   <= 1'b0;
      cry_q   <= 1'b0;
      ea_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      cm_q    <= cm_d;
      tid_q   <= tid_d;
      last_q  <= last_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      val_q   <= val_d;
      cry_q   <= cry_d;
      ea_q    <= ea_d;
    end
  end

  assign t0_req_ack = ack0_q;
  assign t1_req_ack = ack1_q;
  assign res_val    = val_q;
  assign res_tid    = tid_q;
  assign res_ea     = ea_q;
  assign res_cry    = cry_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_lq_agen_seq.sv
// Directed bench for lq_agen_seq: queue of expected results, immediate assertions at each check.
module tb_lq_agen_seq;
  logic        nclk = 1'b0;
  logic        rst_b;
  logic        t0_req_val, t1_req_val, t0_cm, t1_cm;
  logic [63:0] t0_ra, t0_rb, t1_ra, t1_rb;
  logic        t0_req_ack, t1_req_ack;
  logic [1:0]  flush;
  logic        res_hold, res_val, res_tid, res_cry, busy;
  logic [63:0] res_ea;

  typedef struct packed {
    logic        tid;
    logic [63:0] ea;
    logic        cry;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 nclk = ~nclk;

  lq_agen_seq #(.EA_WIDTH(64)) dut (
    .nclk(nclk), .rst_b(rst_b),
    .t0_req_val(t0_req_val), .t1_req_val(t1_req_val),
    .t0_ra(t0_ra), .t1_ra(t1_ra), .t0_rb(t0_rb), .t1_rb(t1_rb),
    .t0_cm(t0_cm), .t1_cm(t1_cm),
    .t0_req_ack(t0_req_ack), .t1_req_ack(t1_req_ack),
    .flush(flush), .res_hold(res_hold),
    .res_val(res_val), .res_tid(res_tid), .res_ea(res_ea),
    .res_cry(res_cry), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic tid, input logic [63:0] ra, input logic [63:0] rb,
                                 input logic cm);
    logic [64:0] s;
    logic [32:0] h;
    exp_t        e;
    e.tid = tid;
    if (cm) begin
      s    = {1'b0, ra} + {1'b0, rb};
      e.ea = s[63:0];
      e.cry = s[64];
    end else begin
      h    = {1'b0, ra[31:0]} + {1'b0, rb[31:0]};
      e.ea = {32'h0, h[31:0]};
      e.cry = h[32];
    end
    return e;
  endfunction

  task automatic drive(input logic tid, input logic [63:0] ra, input logic [63:0] rb,
                       input logic cm);
    if (tid) begin
      t1_req_val = 1'b1; t1_ra = ra; t1_rb = rb; t1_cm = cm;
    end else begin
      t0_req_val = 1'b1; t0_ra = ra; t0_rb = rb; t0_cm = cm;
    end
  endtask

  task automatic pop_chk(input string tag, output exp_t e);
    e = '0;
    chk({tag, "_sb"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_tid"}, 64'(res_tid), 64'(e.tid));
      chk({tag, "_ea"}, res_ea, e.ea);
      chk({tag, "_cry"}, 64'(res_cry), 64'(e.cry));
    end
  endtask

  // Called at a negedge; returns at the first negedge that sees res_val.
  task automatic run_op(input string tag, input logic tid, input logic [63:0] ra,
                        input logic [63:0] rb, input logic cm, input int fl_at,
                        input logic [1:0] fl_v, output exp_t e);
    int n;
    drive(tid, ra, rb, cm);
    sb.push_back(model(tid, ra, rb, cm));
    @(negedge nclk);
    n = 1;
    chk({tag, "_ack"}, 64'({t1_req_ack, t0_req_ack}), tid ? 64'd2 : 64'd1);
    if (tid) t1_req_val = 1'b0; else t0_req_val = 1'b0;
    while (!res_val && n < 14) begin
      flush = (n == fl_at) ? fl_v : 2'b00;
      @(negedge nclk);
      n++;
      if (n == 2) chk({tag, "_ackpulse"}, 64'({t1_req_ack, t0_req_ack}), 64'd0);
    end
    flush = 2'b00;
    chk({tag, "_val"}, 64'(res_val), 64'd1);
    chk({tag, "_lat"}, 64'(n), cm ? 64'd9 : 64'd5);
    pop_chk(tag, e);
  endtask

  task automatic xfer_chk(input string tag);
    @(negedge nclk);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_val"}, 64'(res_val), 64'd0);
  endtask

  initial begin
    exp_t        e;
    int          n;
    logic        seen;
    logic [63:0] ea_hold;
    rst_b = 1'b1; t0_req_val = 0; t1_req_val = 0; t0_cm = 0; t1_cm = 0;
    t0_ra = '0; t0_rb = '0; t1_ra = '0; t1_rb = '0; flush = 2'b00; res_hold = 0;
    #1 rst_b = 1'b0;
    repeat (2) @(negedge nclk);
    chk("rst_val", 64'(res_val), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ea", res_ea, 64'd0);
    chk("rst_misc", 64'({t0_req_ack, t1_req_ack, res_tid, res_cry}), 64'd0);
    rst_b = 1'b1;
    @(negedge nclk);

    run_op("basic", 1'b0, 64'h0000_0000_0000_00FF, 64'h1, 1'b1, 0, 2'b00, e);
    chk("basic_ea_const", res_ea, 64'h100);
    xfer_chk("basic");
    run_op("ripple", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 0, 2'b00, e);
    chk("ripple_cry_const", 64'(res_cry), 64'd1);
    xfer_chk("ripple");
    run_op("byte6", 1'b1, 64'h0000_0000_0000_FFFF, 64'h1, 1'b1, 0, 2'b00, e);
    chk("byte6_ea_const", res_ea, 64'h1_0000);
    xfer_chk("byte6");
    run_op("m32", 1'b0, 64'h1234_5678_FFFF_FFFF, 64'h1, 1'b0, 0, 2'b00, e);
    chk("m32_ea_const", res_ea, 64'h0);
    xfer_chk("m32");
    run_op("rnd64", 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 0, 2'b00, e);
    xfer_chk("rnd64");
    run_op("rnd32", 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 0, 2'b00, e);
    xfer_chk("rnd32");

    // Arbitration: both threads pending from reset, re-requesting after each ack.
    rst_b = 1'b0;
    @(negedge nclk);
    rst_b = 1'b1;
    t0_ra = 64'h10; t0_rb = 64'h20; t0_cm = 1'b1;
    t1_ra = 64'hFFFF_FFFF; t1_rb = 64'h1; t1_cm = 1'b1;
    t0_req_val = 1'b1; t1_req_val = 1'b1;
    for (int g = 0; g < 4; g++) begin
      logic et;
      et = g[0];
      sb.push_back(model(et, et ? t1_ra : t0_ra, et ? t1_rb : t0_rb, 1'b1));
      n = 0;
      do begin @(negedge nclk); n++; end while (!(t0_req_ack | t1_req_ack) && n < 8);
      chk("arb_ack", 64'({t1_req_ack, t0_req_ack}), et ? 64'd2 : 64'd1);
      if (t0_req_ack) t0_req_val = 1'b0;
      if (t1_req_ack) t1_req_val = 1'b0;
      @(negedge nclk);
      t0_req_val = (g < 3); t1_req_val = (g < 3);
      n = 0;
      while (!res_val && n < 14) begin @(negedge nclk); n++; end
      chk("arb_val", 64'(res_val), 64'd1);
      pop_chk("arb", e);
    end
    xfer_chk("arb");

    // Flush t1 at ADD step 3 while t0 waits; t0 is granted in the first IDLE cycle.
    drive(1'b1, 64'h0123_4567_89AB_CDEF, 64'h1111, 1'b1);
    @(negedge nclk);
    chk("fl_ack1", 64'({t1_req_ack, t0_req_ack}), 64'd2);
    t1_req_val = 1'b0;
    repeat (3) @(negedge nclk);
    flush = 2'b10;
    drive(1'b0, 64'h0FF0, 64'h0010, 1'b1);
    sb.push_back(model(1'b0, 64'h0FF0, 64'h0010, 1'b1));
    @(negedge nclk);
    flush = 2'b00;
    chk("fl_busy", 64'(busy), 64'd0);
    chk("fl_val", 64'(res_val), 64'd0);
    @(negedge nclk);
    chk("fl_ack0", 64'({t1_req_ack, t0_req_ack}), 64'd1);
    t0_req_val = 1'b0;
    n = 6;
    while (!res_val && n < 20) begin @(negedge nclk); n++; end
    chk("fl_lat", 64'(n), 64'd14);
    pop_chk("fl_t0", e);
    xfer_chk("fl_t0");

    run_op("oth", 1'b0, 64'h00FF_00FF_00FF_00FF, 64'h0101_0101_0101_0101, 1'b1, 4, 2'b10, e);
    xfer_chk("oth");

    res_hold = 1'b1;
    run_op("hold", 1'b1, 64'h8000_0000_FFFF_FF00, 64'h8000_0000_0000_0100, 1'b1, 0, 2'b00, e);
    ea_hold = e.ea;
    repeat (3) begin
      @(negedge nclk);
      chk("hold_val", 64'(res_val), 64'd1);
      chk("hold_ea", res_ea, ea_hold);
    end
    res_hold = 1'b0;
    xfer_chk("hold");

    res_hold = 1'b1;
    run_op("dfl", 1'b1, 64'h1234, 64'h4321, 1'b0, 0, 2'b00, e);
    flush = 2'b01;
    @(negedge nclk);
    chk("dfl_other_val", 64'(res_val), 64'd1);
    flush = 2'b10;
    @(negedge nclk);
    flush = 2'b00;
    chk("dfl_val", 64'(res_val), 64'd0);
    chk("dfl_busy", 64'(busy), 64'd0);
    res_hold = 1'b0;

    // Reset in the middle of ADD.
    drive(1'b1, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b1);
    @(negedge nclk);
    t1_req_val = 1'b0;
    repeat (2) @(negedge nclk);
    chk("mrst_pre", 64'(res_ea != 64'd0 && res_tid && busy), 64'd1);
    rst_b = 1'b0;
    #1;
    chk("mrst_ea", res_ea, 64'd0);
    chk("mrst_ctl", 64'({busy, res_val, res_tid, res_cry, t0_req_ack, t1_req_ack}), 64'd0);
    @(negedge nclk);
    rst_b = 1'b1;
    @(negedge nclk);
    chk("mrst_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
